// File: rtl/frame_buffer_ctrl.sv
// Multi-bank frame buffer: a source writes down-scaled frames into a ring of banks
// while the display raster reads one bank upscaled, switching banks only at frame boundaries.
module frame_buffer_ctrl #(
    parameter int H_ACTIVE   = 800,
    parameter int V_ACTIVE   = 600,
    parameter int SCALE_LOG2 = 2,
    parameter int PIX_W      = 1,
    parameter int NUM_BANKS  = 2
) (
    input  logic                             CLK_40,
    input  logic                             reset,
    input  logic                             pix_en,
    input  logic                             wr_valid,
    input  logic [PIX_W-1:0]                 wr_data,
    output logic                             wr_ready,
    input  logic                             wr_abort,
    output logic [PIX_W-1:0]                 pixel_out,
    output logic                             pixel_valid,
    output logic [$clog2(H_ACTIVE)-1:0]      x_pos,
    output logic [$clog2(V_ACTIVE)-1:0]      y_pos,
    output logic                             frame_swap,
    output logic                             frame_repeat,
    output logic [$clog2(NUM_BANKS+1)-1:0]   frames_ready
);
    localparam int H_SRC      = H_ACTIVE >> SCALE_LOG2;
    localparam int V_SRC      = V_ACTIVE >> SCALE_LOG2;
    localparam int BANK_DEPTH = H_SRC * V_SRC;
    localparam int AW         = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
    localparam int MEM_DEPTH  = BANK_DEPTH * NUM_BANKS;
    localparam int MAW        = $clog2(MEM_DEPTH);
    localparam int BW         = $clog2(NUM_BANKS);
    localparam int XW         = $clog2(H_ACTIVE);
    localparam int YW         = $clog2(V_ACTIVE);
    localparam int FW         = $clog2(NUM_BANKS + 1);

    localparam logic [MAW-1:0] BANK_DEPTH_M = MAW'(BANK_DEPTH);
    localparam logic [MAW-1:0] H_SRC_M      = MAW'(H_SRC);
    localparam logic [BW-1:0]  LAST_BANK    = BW'(NUM_BANKS - 1);

    logic [XW-1:0]        x_pos_reg;
    logic [YW-1:0]        y_pos_reg;
    logic [AW-1:0]        wr_addr_reg;
    logic [BW-1:0]        wr_bank_reg;
    logic [BW-1:0]        rd_bank_reg;
    logic                 disp_reg;
    logic [NUM_BANKS-1:0] full_reg;
    logic [NUM_BANKS-1:0] full_next;
    logic [PIX_W-1:0]     pixel_out_reg;
    logic                 pixel_valid_reg;
    logic                 frame_swap_reg;
    logic                 frame_repeat_reg;

    logic [PIX_W-1:0]     mem [MEM_DEPTH];

    logic                 wr_fire;
    logic                 commit;
    logic                 end_of_frame;
    logic                 advance;
    logic                 release_bank;
    logic                 repeat_frame;
    logic [BW-1:0]        rd_bank_inc;
    logic [BW-1:0]        wr_bank_inc;
    logic [MAW-1:0]       rd_lin;
    logic [MAW-1:0]       wr_lin;
    logic [FW-1:0]        full_count;

    // The displayed bank stays full until released, so the second term only matters as a guard.
    assign wr_ready     = !full_reg[wr_bank_reg] && !(disp_reg && (wr_bank_reg == rd_bank_reg));
    assign wr_fire      = wr_valid && wr_ready && !wr_abort;
    assign commit       = wr_fire && (wr_addr_reg == AW'(BANK_DEPTH - 1));
    assign end_of_frame = pix_en && (x_pos_reg == XW'(H_ACTIVE - 1)) && (y_pos_reg == YW'(V_ACTIVE - 1));
    assign rd_bank_inc  = (rd_bank_reg == LAST_BANK) ? '0 : rd_bank_reg + BW'(1);
    assign wr_bank_inc  = (wr_bank_reg == LAST_BANK) ? '0 : wr_bank_reg + BW'(1);
    assign advance      = end_of_frame && full_reg[rd_bank_inc];
    // Nothing is released on the very first advance: no bank was being shown yet.
    assign release_bank = advance && disp_reg;
    assign repeat_frame = end_of_frame && !advance && disp_reg;

    assign rd_lin = MAW'(rd_bank_reg) * BANK_DEPTH_M
                  + MAW'(y_pos_reg >> SCALE_LOG2) * H_SRC_M
                  + MAW'(x_pos_reg >> SCALE_LOG2);
    assign wr_lin = MAW'(wr_bank_reg) * BANK_DEPTH_M + MAW'(wr_addr_reg);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_full
            assign full_next[gi] = (full_reg[gi] && !(release_bank && (rd_bank_reg == BW'(gi))))
                                 || (commit && (wr_bank_reg == BW'(gi)));
        end
    endgenerate

    always_comb begin
        full_count = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            full_count = full_count + FW'(full_reg[i]);
        end
    end

    always_ff @(posedge CLK_40) begin
        if (reset) begin
            x_pos_reg        <= '0;
            y_pos_reg        <= '0;
            wr_addr_reg      <= '0;
            wr_bank_reg      <= '0;
            rd_bank_reg      <= LAST_BANK;
            disp_reg         <= 1'b0;
            full_reg         <= '0;
            pixel_valid_reg  <= 1'b0;
            frame_swap_reg   <= 1'b0;
            frame_repeat_reg <= 1'b0;
        end else begin
            pixel_valid_reg  <= pix_en;
            frame_swap_reg   <= advance;
            frame_repeat_reg <= repeat_frame;
            full_reg         <= full_next;

            if (pix_en) begin
                if (x_pos_reg == XW'(H_ACTIVE - 1)) begin
                    x_pos_reg <= '0;
                    y_pos_reg <= (y_pos_reg == YW'(V_ACTIVE - 1)) ? '0 : y_pos_reg + YW'(1);
                end else begin
                    x_pos_reg <= x_pos_reg + XW'(1);
                end
            end

            if (advance) begin
                rd_bank_reg <= rd_bank_inc;
                disp_reg    <= 1'b1;
            end

            if (wr_abort) begin
                wr_addr_reg <= '0;
            end else if (commit) begin
                wr_addr_reg <= '0;
                wr_bank_reg <= wr_bank_inc;
            end else if (wr_fire) begin
                wr_addr_reg <= wr_addr_reg + AW'(1);
            end
        end
    end

    always_ff @(posedge CLK_40) begin
        if (wr_fire && !reset) begin
            mem[wr_lin] <= wr_data;
        end
    end

    // Registered read; blank output until a committed bank is on display.
    always_ff @(posedge CLK_40) begin
        if (reset) begin
            pixel_out_reg <= '0;
        end else if (pix_en) begin
            pixel_out_reg <= disp_reg ? mem[rd_lin] : '0;
        end
    end

    assign pixel_out    = pixel_out_reg;
    assign pixel_valid  = pixel_valid_reg;
    assign x_pos        = x_pos_reg;
    assign y_pos        = y_pos_reg;
    assign frame_swap   = frame_swap_reg;
    assign frame_repeat = frame_repeat_reg;
    assign frames_ready = full_count;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Directed bench for frame_buffer_ctrl at 8x4 display, 2x upscale, 2-bit pixels;
// a two-bank and a three-bank instance share the same stimulus.
module tb_frame_buffer_ctrl;
    logic       CLK_40 = 1'b0;
    logic       reset = 1'b1;
    logic       pix_en = 1'b0;
    logic       wr_valid = 1'b0;
    logic [1:0] wr_data = 2'd0;
    logic       wr_abort = 1'b0;

    logic       wr_ready, pixel_valid, frame_swap, frame_repeat;
    logic [1:0] pixel_out, frames_ready;
    logic [2:0] x_pos;
    logic [1:0] y_pos;

    logic       wr_ready_b, pixel_valid_b, frame_swap_b, frame_repeat_b;
    logic [1:0] pixel_out_b, frames_ready_b;
    logic [2:0] x_pos_b;
    logic [1:0] y_pos_b;

    int checks = 0;
    int errors = 0;
    int bx = 0;
    int by = 0;

    always #12 CLK_40 = ~CLK_40;

    frame_buffer_ctrl #(.H_ACTIVE(8), .V_ACTIVE(4), .SCALE_LOG2(1), .PIX_W(2), .NUM_BANKS(2)) dut (
        .CLK_40(CLK_40), .reset(reset), .pix_en(pix_en), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .wr_abort(wr_abort), .pixel_out(pixel_out), .pixel_valid(pixel_valid),
        .x_pos(x_pos), .y_pos(y_pos), .frame_swap(frame_swap), .frame_repeat(frame_repeat),
        .frames_ready(frames_ready));

    frame_buffer_ctrl #(.H_ACTIVE(8), .V_ACTIVE(4), .SCALE_LOG2(1), .PIX_W(2), .NUM_BANKS(3)) dut3 (
        .CLK_40(CLK_40), .reset(reset), .pix_en(pix_en), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready_b), .wr_abort(wr_abort), .pixel_out(pixel_out_b), .pixel_valid(pixel_valid_b),
        .x_pos(x_pos_b), .y_pos(y_pos_b), .frame_swap(frame_swap_b), .frame_repeat(frame_repeat_b),
        .frames_ready(frames_ready_b));

    task automatic tick();
        @(posedge CLK_40);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; pix_en = 1'b0; wr_valid = 1'b0; wr_abort = 1'b0;
        tick();
        reset = 1'b0;
        bx = 0; by = 0;
    endtask

    task automatic write_px(input logic [1:0] d);
        wr_valid = 1'b1; wr_data = d;
        tick();
        wr_valid = 1'b0;
    endtask

    // value at address a is (a*step + base) mod 4
    task automatic write_frame(input int base, input int step);
        for (int a = 0; a < 8; a++) write_px(2'((a * step + base) % 4));
    endtask

    // mode 0: blank, 1: a mod 4 pattern, 2: constant 3
    task automatic run_pix(input int n, input int mode, output int swaps, output int reps);
        logic [1:0] exp_px;
        int a;
        swaps = 0; reps = 0;
        for (int i = 0; i < n; i++) begin
            a = (by / 2) * 4 + (bx / 2);
            exp_px = (mode == 0) ? 2'd0 : (mode == 1) ? 2'(a % 4) : 2'd3;
            pix_en = 1'b1;
            tick();
            checks++;
            if (pixel_valid !== 1'b1 || pixel_out !== exp_px) begin
                errors++;
                $display("FAIL pixel x=%0d y=%0d got valid=%0b data=%0d exp valid=1 data=%0d",
                         bx, by, pixel_valid, pixel_out, exp_px);
            end
            if (frame_swap === 1'b1) swaps++;
            if (frame_repeat === 1'b1) reps++;
            bx = (bx == 7) ? 0 : bx + 1;
            if (bx == 0) by = (by == 3) ? 0 : by + 1;
            checks++;
            if (x_pos !== 3'(bx) || y_pos !== 2'(by)) begin
                errors++;
                $display("FAIL raster got x=%0d y=%0d exp x=%0d y=%0d", x_pos, y_pos, bx, by);
            end
        end
        pix_en = 1'b0;
        tick();
        checks++;
        if (pixel_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_idle got %0b exp 0", pixel_valid);
        end
    endtask

    task automatic check_reset_state(input string tag);
        checks++;
        if (x_pos !== 3'd0 || y_pos !== 2'd0 || wr_ready !== 1'b1 || frames_ready !== 2'd0 ||
            pixel_out !== 2'd0 || pixel_valid !== 1'b0 || frame_swap !== 1'b0 || frame_repeat !== 1'b0) begin
            errors++;
            $display("FAIL %s got x=%0d y=%0d rdy=%0b fr=%0d px=%0d pv=%0b sw=%0b rp=%0b exp 0 0 1 0 0 0 0 0",
                     tag, x_pos, y_pos, wr_ready, frames_ready, pixel_out, pixel_valid, frame_swap, frame_repeat);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_reset_state("reset_state");
        checks++;
        if (frames_ready_b !== 2'd0 || wr_ready_b !== 1'b1) begin
            errors++;
            $display("FAIL reset_state_b got fr=%0d rdy=%0b exp 0 1", frames_ready_b, wr_ready_b);
        end
        $display("test_reset done");
    endtask

    task automatic test_swap();
        int s, r;
        do_reset();
        write_frame(0, 1);
        checks++;
        if (frames_ready !== 2'd1 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL swap_commit got fr=%0d rdy=%0b exp 1 1", frames_ready, wr_ready);
        end
        run_pix(32, 0, s, r);
        checks++;
        if (s != 1 || r != 0) begin
            errors++;
            $display("FAIL swap_pulse got swaps=%0d repeats=%0d exp 1 0", s, r);
        end
        // 11th pixel of the new frame is x=2,y=1 -> address 1 -> value 1
        run_pix(11, 1, s, r);
        $display("test_swap done");
    endtask

    task automatic test_repeat();
        int s, r, st, rt;
        do_reset();
        write_frame(0, 1);
        run_pix(32, 0, s, r);
        st = 0; rt = 0;
        for (int f = 0; f < 2; f++) begin
            run_pix(32, 1, s, r);
            st += s; rt += r;
        end
        checks++;
        if (st != 0 || rt != 2) begin
            errors++;
            $display("FAIL repeat_pulses got swaps=%0d repeats=%0d exp 0 2", st, rt);
        end
        checks++;
        if (frames_ready !== 2'd1) begin
            errors++;
            $display("FAIL repeat_ready got %0d exp 1", frames_ready);
        end
        $display("test_repeat done");
    endtask

    task automatic test_full();
        int s, r;
        do_reset();
        write_frame(0, 1);
        write_frame(3, 0);
        checks++;
        if (frames_ready !== 2'd2 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_state got fr=%0d rdy=%0b exp 2 0", frames_ready, wr_ready);
        end
        for (int i = 0; i < 4; i++) write_px(2'd2);
        checks++;
        if (frames_ready !== 2'd2 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ignore got fr=%0d rdy=%0b exp 2 0", frames_ready, wr_ready);
        end
        run_pix(32, 0, s, r);
        run_pix(32, 1, s, r);
        checks++;
        if (s != 1 || frames_ready !== 2'd1 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_release got swaps=%0d fr=%0d rdy=%0b exp 1 1 1", s, frames_ready, wr_ready);
        end
        run_pix(32, 2, s, r);
        $display("test_full done");
    endtask

    task automatic test_abort();
        int s, r;
        do_reset();
        for (int i = 0; i < 5; i++) write_px(2'd1);
        wr_abort = 1'b1; wr_valid = 1'b1; wr_data = 2'd2;
        tick();
        wr_abort = 1'b0; wr_valid = 1'b0;
        for (int i = 0; i < 7; i++) write_px(2'd3);
        checks++;
        if (frames_ready !== 2'd0) begin
            errors++;
            $display("FAIL abort_partial got fr=%0d exp 0", frames_ready);
        end
        write_px(2'd3);
        checks++;
        if (frames_ready !== 2'd1) begin
            errors++;
            $display("FAIL abort_commit got fr=%0d exp 1", frames_ready);
        end
        run_pix(32, 0, s, r);
        run_pix(32, 2, s, r);
        $display("test_abort done");
    endtask

    task automatic test_commit_release();
        int s, r;
        do_reset();
        write_frame(0, 1);
        run_pix(32, 0, s, r);
        write_frame(3, 0);
        for (int i = 0; i < 7; i++) write_px(2'd2);
        checks++;
        if (frames_ready_b !== 2'd2 || wr_ready_b !== 1'b1) begin
            errors++;
            $display("FAIL cr_before got fr=%0d rdy=%0b exp 2 1", frames_ready_b, wr_ready_b);
        end
        run_pix(31, 1, s, r);
        pix_en = 1'b1; wr_valid = 1'b1; wr_data = 2'd2;
        tick();
        pix_en = 1'b0; wr_valid = 1'b0;
        bx = 0; by = 0;
        checks++;
        if (frame_swap_b !== 1'b1 || frame_repeat_b !== 1'b0 || frames_ready_b !== 2'd2 || wr_ready_b !== 1'b1) begin
            errors++;
            $display("FAIL cr_same_cycle got sw=%0b rp=%0b fr=%0d rdy=%0b exp 1 0 2 1",
                     frame_swap_b, frame_repeat_b, frames_ready_b, wr_ready_b);
        end
        checks++;
        if (frame_swap !== 1'b1 || frames_ready !== 2'd1) begin
            errors++;
            $display("FAIL cr_two_bank got sw=%0b fr=%0d exp 1 1", frame_swap, frames_ready);
        end
        tick();
        checks++;
        if (frame_swap_b !== 1'b0) begin
            errors++;
            $display("FAIL cr_pulse_width got %0b exp 0", frame_swap_b);
        end
        $display("test_commit_release done");
    endtask

    task automatic test_reset_mid();
        int s, r;
        do_reset();
        write_frame(0, 1);
        write_frame(3, 0);
        run_pix(32, 0, s, r);
        run_pix(13, 1, s, r);
        checks++;
        if (frames_ready !== 2'd2) begin
            errors++;
            $display("FAIL mid_setup got fr=%0d exp 2", frames_ready);
        end
        reset = 1'b1; pix_en = 1'b1;
        tick();
        reset = 1'b0; pix_en = 1'b0;
        bx = 0; by = 0;
        check_reset_state("mid_reset_state");
        run_pix(32, 0, s, r);
        checks++;
        if (s != 0 || r != 0 || frames_ready !== 2'd0) begin
            errors++;
            $display("FAIL mid_after got swaps=%0d repeats=%0d fr=%0d exp 0 0 0", s, r, frames_ready);
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_swap();
        test_repeat();
        test_full();
        test_abort();
        test_commit_release();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end
endmodule
